// File: rtl/seg_mult_scan.sv
// seg_mult_scan: 4x4 shift-add multiplier with double-dabble BCD conversion.
// The three held digits are time-multiplexed onto one active-low segment bus.
module seg_mult_scan #(
    parameter int SCAN_DIV = 4,
    parameter int BLANK    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic       busy,
    output logic       done,
    output logic [7:0] product,
    output logic [6:0] seg,
    output logic [2:0] an
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    typedef enum logic [1:0] {IDLE, MUL, CONV} state_t;

    state_t      state_reg, state_next;
    logic [7:0]  mcand_reg, mcand_next;
    logic [3:0]  mplier_reg, mplier_next;
    logic [7:0]  acc_reg, acc_next;
    logic [2:0]  step_reg, step_next;
    logic [19:0] dbl_reg, dbl_next;
    logic        busy_reg, busy_next;
    logic        done_reg, done_next;
    logic [7:0]  product_reg, product_next;
    logic [3:0]  d2_reg, d2_next, d1_reg, d1_next, d0_reg, d0_next;
    logic [CW-1:0] scan_cnt_reg, scan_cnt_next;
    logic [1:0]  idx_reg, idx_next;
    logic [2:0]  an_reg, an_next;
    logic [6:0]  seg_reg, seg_next;
    logic [19:0] dbl_step;
    logic [7:0]  acc_sum;
    logic [3:0]  digit_sel;
    logic        digit_blank;

    // One double-dabble step: bias BCD nibbles >= 5 by 3, then shift left.
    function automatic logic [19:0] dabble(input logic [19:0] v);
        logic [19:0] t;
        t = v;
        for (int i = 0; i < 3; i++) begin
            if (t[8 + 4*i +: 4] >= 4'd5)
                t[8 + 4*i +: 4] = t[8 + 4*i +: 4] + 4'd3;
        end
        return {t[18:0], 1'b0};
    endfunction

    // Active-low 7-segment decode, bit6..bit0 = a..g.
    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b0000001;
            4'd1:    return 7'b1001111;
            4'd2:    return 7'b0010010;
            4'd3:    return 7'b0000110;
            4'd4:    return 7'b1001100;
            4'd5:    return 7'b0100100;
            4'd6:    return 7'b0100000;
            4'd7:    return 7'b0001111;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0000100;
            default: return 7'b1111111;
        endcase
    endfunction

    assign dbl_step = dabble(dbl_reg);
    assign acc_sum  = acc_reg + (mplier_reg[0] ? mcand_reg : 8'd0);

    // Compute FSM next state: operand latch, multiply steps, BCD steps, result load.
    always_comb begin
        state_next   = state_reg;
        mcand_next   = mcand_reg;
        mplier_next  = mplier_reg;
        acc_next     = acc_reg;
        step_next    = step_reg;
        dbl_next     = dbl_reg;
        busy_next    = busy_reg;
        done_next    = 1'b0;
        product_next = product_reg;
        d2_next      = d2_reg;
        d1_next      = d1_reg;
        d0_next      = d0_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    mcand_next  = {4'd0, a};
                    mplier_next = b;
                    acc_next    = 8'd0;
                    step_next   = 3'd0;
                    busy_next   = 1'b1;
                    state_next  = MUL;
                end
            end
            MUL: begin
                acc_next    = acc_sum;
                mcand_next  = {mcand_reg[6:0], 1'b0};
                mplier_next = {1'b0, mplier_reg[3:1]};
                step_next   = step_reg + 3'd1;
                if (step_reg == 3'd3) begin
                    // Seed the conversion register with the finished product.
                    dbl_next   = {12'd0, acc_sum};
                    step_next  = 3'd0;
                    state_next = CONV;
                end
            end
            CONV: begin
                dbl_next  = dbl_step;
                step_next = step_reg + 3'd1;
                if (step_reg == 3'd7) begin
                    product_next = acc_reg;
                    d2_next      = dbl_step[19:16];
                    d1_next      = dbl_step[15:12];
                    d0_next      = dbl_step[11:8];
                    busy_next    = 1'b0;
                    done_next    = 1'b1;
                    state_next   = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Compute scan position and the matching segment pattern; built from the
    // next digit values so new digits appear on the bus at the load edge.
    always_comb begin
        scan_cnt_next = scan_cnt_reg + CW'(1);
        idx_next      = idx_reg;
        if (scan_cnt_reg == CW'(SCAN_DIV - 1)) begin
            scan_cnt_next = '0;
            idx_next      = (idx_reg == 2'd2) ? 2'd0 : idx_reg + 2'd1;
        end
        digit_sel   = d0_next;
        digit_blank = 1'b0;
        an_next     = 3'b110;
        case (idx_next)
            2'd1: begin
                digit_sel   = d1_next;
                digit_blank = (BLANK != 0) && (d2_next == 4'd0) && (d1_next == 4'd0);
                an_next     = 3'b101;
            end
            2'd2: begin
                digit_sel   = d2_next;
                digit_blank = (BLANK != 0) && (d2_next == 4'd0);
                an_next     = 3'b011;
            end
            default: begin
                digit_sel   = d0_next;
                digit_blank = 1'b0;
                an_next     = 3'b110;
            end
        endcase
        seg_next = digit_blank ? 7'b1111111 : decode(digit_sel);
    end

    // State and display registers; reset aborts any computation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            mcand_reg    <= 8'd0;
            mplier_reg   <= 4'd0;
            acc_reg      <= 8'd0;
            step_reg     <= 3'd0;
            dbl_reg      <= 20'd0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            product_reg  <= 8'd0;
            d2_reg       <= 4'd0;
            d1_reg       <= 4'd0;
            d0_reg       <= 4'd0;
            scan_cnt_reg <= '0;
            idx_reg      <= 2'd0;
            an_reg       <= 3'b110;
            seg_reg      <= 7'b0000001;
        end else begin
            state_reg    <= state_next;
            mcand_reg    <= mcand_next;
            mplier_reg   <= mplier_next;
            acc_reg      <= acc_next;
            step_reg     <= step_next;
            dbl_reg      <= dbl_next;
            busy_reg     <= busy_next;
            done_reg     <= done_next;
            product_reg  <= product_next;
            d2_reg       <= d2_next;
            d1_reg       <= d1_next;
            d0_reg       <= d0_next;
            scan_cnt_reg <= scan_cnt_next;
            idx_reg      <= idx_next;
            an_reg       <= an_next;
            seg_reg      <= seg_next;
        end
    end

    assign busy    = busy_reg;
    assign done    = done_reg;
    assign product = product_reg;
    assign seg     = seg_reg;
    assign an      = an_reg;

endmodule
